dmem_write_buffer: RTL

//  Posted-write buffer between the PCPU data port and slow data RAM. Absorbs

---
 rtl/dmem_write_buffer_pkg.sv | 19 +
 rtl/dmem_write_buffer_store.sv | 72 +++++++
 rtl/dmem_write_buffer.sv | 117 +++++++++++
 3 files changed

// File: rtl/dmem_write_buffer_pkg.sv
// Shared types and sizing helpers for the data-memory posted-write buffer.
// Drain FSM encodings and the count-width rule live here so the store and top agree.
package dmem_write_buffer_pkg;

    localparam int WBF_DEPTH_DEFAULT = 4;
    localparam int WBF_AW_DEFAULT    = 16;
    localparam int WBF_DW_DEFAULT    = 16;

    typedef enum logic [0:0] {
        WBF_IDLE  = 1'b0,
        WBF_WRITE = 1'b1
    } wbf_state_t;

    // The count must be able to hold DEPTH itself, not just DEPTH-1.
    function automatic int wbf_count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dmem_write_buffer_store.sv
// Entry storage for the write buffer: circular array with valid bits, head/tail
// pointers, and a youngest-match address search used for load forwarding.
module wbuf_store #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    input  logic [AW-1:0] lookup_addr,
    output logic [AW-1:0] head_addr,
    output logic [DW-1:0] head_data,
    output logic          hit,
    output logic [DW-1:0] hit_data
);

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [PW-1:0]    idx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PW'(1);
            end
            if (push) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PW'(1);
            end
        end
    end

    // Payload needs no reset: valid bits alone decide whether an entry exists.
    always_ff @(posedge clock) begin
        if (push) begin
            addr_q[tail_q] <= push_addr;
            data_q[tail_q] <= push_data;
        end
    end

    assign head_addr = addr_q[head_q];
    assign head_data = data_q[head_q];

    // Walk from oldest (furthest behind tail) to youngest so the youngest match wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            idx = tail_q - PW'(k) - PW'(1);
            if (valid_q[idx] && (addr_q[idx] == lookup_addr)) begin
                hit      = 1'b1;
                hit_data = data_q[idx];
            end
        end
    end

endmodule

// File: rtl/dmem_write_buffer.sv
// Posted-write buffer between the PCPU data port and slow data RAM: absorbs stores,
// drains them over a req/ack port, forwards buffered data to loads, supports flush.
module dmem_write_buffer
    import dmem_write_buffer_pkg::*;
#(
    parameter int DEPTH = WBF_DEPTH_DEFAULT,
    parameter int AW    = WBF_AW_DEFAULT,
    parameter int DW    = WBF_DW_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_dataout,
    input  logic          d_we,
    output logic [DW-1:0] d_datain,
    output logic          stall,
    input  logic          flush,
    output logic          flush_done,
    output logic          empty,
    output logic [AW-1:0] mem_raddr,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_wreq,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_wack,
    output wbf_state_t    fsm_state
);

    localparam int CW = wbf_count_width(DEPTH);

    wbf_state_t    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          flush_pending_q, flush_pending_d;
    logic          flush_done_q;
    logic          push, pop;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;
    logic          hit;
    logic [DW-1:0] hit_data;

    // Stall looks only at registered count: a pop on a full cycle frees nothing yet.
    assign stall = d_we && ((count_q == CW'(DEPTH)) || flush_pending_q);
    assign push  = d_we && !stall;
    assign pop   = (state_q == WBF_WRITE) && mem_wack;

    wbuf_store #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_store (
        .clock       (clock),
        .reset       (reset),
        .push        (push),
        .pop         (pop),
        .push_addr   (d_addr),
        .push_data   (d_dataout),
        .lookup_addr (d_addr),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .hit         (hit),
        .hit_data    (hit_data)
    );

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WBF_IDLE:  if (count_q != '0) state_d = WBF_WRITE;
            WBF_WRITE: if (pop && (count_d == '0)) state_d = WBF_IDLE;
            default:   state_d = WBF_IDLE;
        endcase
    end

    // Clearing wins over a held flush so a held request produces separate pulses.
    always_comb begin
        flush_pending_d = flush_pending_q;
        if (flush_pending_q && (count_q == '0)) begin
            flush_pending_d = 1'b0;
        end else if (flush) begin
            flush_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= WBF_IDLE;
            count_q         <= '0;
            flush_pending_q <= 1'b0;
            flush_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            flush_pending_q <= flush_pending_d;
            flush_done_q    <= flush_pending_q && (count_q == '0);
        end
    end

    // Write port: mem_wreq high holds addr/data stable; an edge with mem_wack high
    // completes the transfer of the head entry. mem_wack outside WRITE is ignored.
    assign mem_wreq   = (state_q == WBF_WRITE);
    assign mem_waddr  = mem_wreq ? head_addr : '0;
    assign mem_wdata  = mem_wreq ? head_data : '0;
    assign mem_raddr  = d_addr;
    assign d_datain   = hit ? hit_data : mem_rdata;
    assign empty      = (count_q == '0);
    assign flush_done = flush_done_q;
    assign fsm_state  = state_q;

endmodule
